dsp_div_signed_seq: RTL and testbench

Sequential signed divider that inverts the signed 20x18 combinational multiplier. It recovers the 20-bit multiplicand from a 38-bit product and the 18-bit multiplier. The datapath is radix-2, one quotient bit per clock, with valid/ready handshakes on both input and output. It sits in the DSP designs group beside the signed multiplier, so product/operand round-trip benches can pair the two blocks.

---
 rtl/dsp_div_pkg.sv | 25 ++
 rtl/dsp_div_unsigned_core.sv | 88 ++++++++
 rtl/dsp_div_signed_seq.sv | 172 +++++++++++++++++
 tb/tb_dsp_div_signed_seq.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/dsp_div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dsp_div_pkg
// Purpose  : Shared widths, FSM state encoding and quotient range limits
//            for the sequential signed divider.
// Revision : 1.0 - initial release
// ============================================================================
package dsp_div_pkg;

    localparam int DW = 38;
    localparam int VW = 18;
    localparam int QW = 20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    localparam logic [QW-1:0] QMAX = {1'b0, {(QW-1){1'b1}}};
    localparam logic [QW-1:0] QMIN = {1'b1, {(QW-1){1'b0}}};

endpackage
`default_nettype wire

// File: rtl/dsp_div_unsigned_core.sv
`default_nettype none
// ============================================================================
// Module   : dsp_div_unsigned_core
// Purpose  : Restoring radix-2 magnitude divider, one quotient bit per clock.
//            done is high during the cycle whose edge performs the last step.
// Revision : 1.0 - initial release
// ============================================================================
module dsp_div_unsigned_core #(
    parameter int DW = 38,
    parameter int VW = 18
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] dvd_mag,
    input  logic [VW-1:0] dvs_mag,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quot,
    output logic [VW-1:0] rem
);
    import dsp_div_pkg::*;

    localparam int CW = $clog2(DW + 1);

    logic [DW-1:0] quot_q, quot_d;
    logic [VW-1:0] rem_q, rem_d;
    logic [VW-1:0] dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;

    logic [VW:0]   w_trial;
    logic [VW:0]   w_diff;
    logic          w_ge;

    // Dividend bits shift out of the top of the quotient register as
    // quotient bits shift in at the bottom.
    assign w_trial = {rem_q, quot_q[DW-1]};
    assign w_diff  = w_trial - {1'b0, dvs_q};
    assign w_ge    = (w_trial >= {1'b0, dvs_q});

    always_comb begin
        quot_d = quot_q;
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start && !busy_q) begin
            quot_d = dvd_mag;
            rem_d  = '0;
            dvs_d  = dvs_mag;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            quot_d = {quot_q[DW-2:0], w_ge};
            rem_d  = w_ge ? w_diff[VW-1:0] : w_trial[VW-1:0];
            if (cnt_q == CW'(DW - 1)) begin
                cnt_d  = '0;
                busy_d = 1'b0;
            end else begin
                cnt_d  = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quot_q <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            quot_q <= quot_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;
    assign done = busy_q && (cnt_q == CW'(DW - 1));
    assign quot = quot_q;
    assign rem  = rem_q;

endmodule
`default_nettype wire

// File: rtl/dsp_div_signed_seq.sv
`default_nettype none
// ============================================================================
// Module   : dsp_div_signed_seq
// Purpose  : Sequential signed divider with valid/ready handshakes; recovers
//            the multiplicand of the signed 20x18 multiplier. Define
//            DSP_DIV_SAT_EN to saturate the quotient on overflow.
// Revision : 1.0 - initial release
// ============================================================================
module dsp_div_signed_seq #(
    parameter int DW = dsp_div_pkg::DW,
    parameter int VW = dsp_div_pkg::VW,
    parameter int QW = dsp_div_pkg::QW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [QW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          overflow,
    output logic          div_by_zero
);
    import dsp_div_pkg::*;

    localparam logic [QW-1:0] c_QMAX   = {1'b0, {(QW-1){1'b1}}};
    localparam logic [QW-1:0] c_QMIN   = {1'b1, {(QW-1){1'b0}}};
    localparam logic [DW:0]   c_QMAX_X = {{(DW-QW+2){1'b0}}, {(QW-1){1'b1}}};
    localparam logic [DW:0]   c_QMIN_X = {{(DW-QW+2){1'b1}}, {(QW-1){1'b0}}};

    div_state_e    state_q, state_d;
    logic          dvd_neg_q, dvd_neg_d;
    logic          dvs_neg_q, dvs_neg_d;
    logic          zero_q, zero_d;
    logic [QW-1:0] quotient_q, quotient_d;
    logic [VW-1:0] remainder_q, remainder_d;
    logic          overflow_q, overflow_d;
    logic          div_by_zero_q, div_by_zero_d;

    logic          w_accept;
    logic          w_div_zero;
    logic          w_core_start;
    logic          w_core_busy;
    logic          w_core_done;
    logic [DW-1:0] w_core_quot;
    logic [VW-1:0] w_core_rem;
    logic [DW-1:0] w_dvd_mag;
    logic [VW-1:0] w_dvs_mag;
    logic          w_neg;
    logic [DW:0]   w_q_full;
    logic          w_ovf;
    logic [QW-1:0] w_q_out;
    logic [VW-1:0] w_r_out;

    assign in_ready     = (state_q == IDLE);
    assign out_valid    = (state_q == DONE);
    assign w_accept     = in_valid && in_ready;
    assign w_div_zero   = (divisor == '0);
    assign w_core_start = w_accept && !w_div_zero;

    assign w_dvd_mag = dividend[DW-1] ? (~dividend + DW'(1)) : dividend;
    assign w_dvs_mag = divisor[VW-1]  ? (~divisor + VW'(1))  : divisor;

    dsp_div_unsigned_core #(
        .DW (DW),
        .VW (VW)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (w_core_start),
        .dvd_mag (w_dvd_mag),
        .dvs_mag (w_dvs_mag),
        .busy    (w_core_busy),
        .done    (w_core_done),
        .quot    (w_core_quot),
        .rem     (w_core_rem)
    );

    // One extra bit keeps the full-magnitude quotient signed before range check.
    assign w_neg    = dvd_neg_q ^ dvs_neg_q;
    assign w_q_full = w_neg ? (~{1'b0, w_core_quot} + (DW+1)'(1)) : {1'b0, w_core_quot};
    assign w_ovf    = ($signed(w_q_full) > $signed(c_QMAX_X)) ||
                      ($signed(w_q_full) < $signed(c_QMIN_X));
    assign w_r_out  = dvd_neg_q ? (~w_core_rem + VW'(1)) : w_core_rem;

`ifdef DSP_DIV_SAT_EN
    assign w_q_out = w_ovf ? (w_neg ? c_QMIN : c_QMAX) : w_q_full[QW-1:0];
`else
    assign w_q_out = w_q_full[QW-1:0];
`endif

    always_comb begin
        state_d       = state_q;
        dvd_neg_d     = dvd_neg_q;
        dvs_neg_d     = dvs_neg_q;
        zero_d        = zero_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        overflow_d    = overflow_q;
        div_by_zero_d = div_by_zero_q;
        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    dvd_neg_d = dividend[DW-1];
                    dvs_neg_d = divisor[VW-1];
                    zero_d    = w_div_zero;
                    state_d   = w_div_zero ? FIX : CALC;
                end
            end
            CALC: begin
                // Core idle while in CALC cannot occur normally; recover to IDLE.
                if (w_core_done) begin
                    state_d = FIX;
                end else if (!w_core_busy) begin
                    state_d = IDLE;
                end
            end
            FIX: begin
                if (zero_q) begin
                    quotient_d    = '0;
                    remainder_d   = '0;
                    overflow_d    = 1'b0;
                    div_by_zero_d = 1'b1;
                end else begin
                    quotient_d    = w_q_out;
                    remainder_d   = w_r_out;
                    overflow_d    = w_ovf;
                    div_by_zero_d = 1'b0;
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            dvd_neg_q     <= 1'b0;
            dvs_neg_q     <= 1'b0;
            zero_q        <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            overflow_q    <= 1'b0;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            dvd_neg_q     <= dvd_neg_d;
            dvs_neg_q     <= dvs_neg_d;
            zero_q        <= zero_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            overflow_q    <= overflow_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign overflow    = overflow_q;
    assign div_by_zero = div_by_zero_q;

endmodule
`default_nettype wire

// File: tb/tb_dsp_div_signed_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_dsp_div_signed_seq
// Purpose  : Directed self-checking bench for the sequential signed divider.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dsp_div_signed_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [37:0] dividend;
    logic [17:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] quotient;
    logic [17:0] remainder;
    logic        overflow;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;

    logic signed [19:0] ra;
    logic signed [17:0] rb;
    logic signed [37:0] rp;

    dsp_div_signed_seq u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .overflow    (overflow),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Offer one operation from a falling edge; returns just after the accept edge.
    task automatic launch(input logic [37:0] dvd, input logic [17:0] dvs);
        @(negedge clk);
        check("in_ready before accept", {63'd0, in_ready}, 64'sd1);
        dividend = dvd;
        divisor  = dvs;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int exp_lat);
        int k = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid === 1'b1) begin
                k = i;
                break;
            end
        end
        check({tag, " latency"}, k, exp_lat);
    endtask

    task automatic check_result(input string tag, input logic signed [63:0] q,
                                input logic signed [63:0] r, input logic ov,
                                input logic dz);
        check({tag, " quotient"},    $signed(quotient),  q);
        check({tag, " remainder"},   $signed(remainder), r);
        check({tag, " overflow"},    {63'd0, overflow},    {63'd0, ov});
        check({tag, " div_by_zero"}, {63'd0, div_by_zero}, {63'd0, dz});
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check({tag, " out_valid after release"}, {63'd0, out_valid}, 64'sd0);
        check({tag, " in_ready after release"},  {63'd0, in_ready},  64'sd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset out_valid",   {63'd0, out_valid},   64'sd0);
        check("reset quotient",    $signed(quotient),    64'sd0);
        check("reset remainder",   $signed(remainder),   64'sd0);
        check("reset overflow",    {63'd0, overflow},    64'sd0);
        check("reset div_by_zero", {63'd0, div_by_zero}, 64'sd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready after reset", {63'd0, in_ready}, 64'sd1);

        launch(38'd10, 18'd2);
        wait_valid("10/2", 39);
        check_result("10/2", 5, 0, 1'b0, 1'b0);
        release_out("10/2");

        launch(-38'sd7, 18'd2);
        wait_valid("-7/2", 39);
        check_result("-7/2", -3, -1, 1'b0, 1'b0);
        release_out("-7/2");

        launch(38'd7, -18'sd2);
        wait_valid("7/-2", 39);
        check_result("7/-2", -3, 1, 1'b0, 1'b0);
        release_out("7/-2");

        launch(-38'sd7, -18'sd2);
        wait_valid("-7/-2", 39);
        check_result("-7/-2", 3, -1, 1'b0, 1'b0);
        release_out("-7/-2");

        for (int i = 0; i < 32; i++) begin
            ra = 20'($urandom);
            rb = 18'($urandom);
            if (rb == 0) rb = 18'sd1;
            rp = ra * rb;
            launch(rp, rb);
            wait_valid("round trip", 39);
            check_result("round trip", ra, 0, 1'b0, 1'b0);
            release_out("round trip");
        end

        launch(38'd524288, 18'd1);
        wait_valid("ovf 524288/1", 39);
`ifdef DSP_DIV_SAT_EN
        check_result("ovf 524288/1", 524287, 0, 1'b1, 1'b0);
`else
        check_result("ovf 524288/1", -524288, 0, 1'b1, 1'b0);
`endif
        release_out("ovf 524288/1");

        launch(-38'sd524288, 18'd1);
        wait_valid("-524288/1", 39);
        check_result("-524288/1", -524288, 0, 1'b0, 1'b0);
        release_out("-524288/1");

        launch(38'd12345, 18'd0);
        wait_valid("12345/0", 1);
        check_result("12345/0", 0, 0, 1'b0, 1'b1);
        release_out("12345/0");

        // Backpressure: result must hold and new offers must be ignored.
        launch(-38'sd1000, 18'd7);
        wait_valid("-1000/7", 39);
        check_result("-1000/7", -142, -6, 1'b0, 1'b0);
        dividend = 38'd555;
        divisor  = 18'd5;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("stall quotient",  $signed(quotient),  -64'sd142);
            check("stall remainder", $signed(remainder), -64'sd6);
            check("stall out_valid", {63'd0, out_valid}, 64'sd1);
            check("stall in_ready",  {63'd0, in_ready},  64'sd0);
        end
        dividend  = 38'd100;
        divisor   = 18'd7;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("turnaround in_ready",  {63'd0, in_ready},  64'sd1);
        check("turnaround out_valid", {63'd0, out_valid}, 64'sd0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("busy after accept", {63'd0, in_ready}, 64'sd0);
        wait_valid("100/7", 39);
        check_result("100/7", 14, 2, 1'b0, 1'b0);
        release_out("100/7");

        // Reset in the middle of an operation.
        launch(38'd1000, 18'd3);
        repeat (20) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset out_valid",   {63'd0, out_valid},   64'sd0);
        check("midreset quotient",    $signed(quotient),    64'sd0);
        check("midreset remainder",   $signed(remainder),   64'sd0);
        check("midreset overflow",    {63'd0, overflow},    64'sd0);
        check("midreset div_by_zero", {63'd0, div_by_zero}, 64'sd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midreset in_ready", {63'd0, in_ready}, 64'sd1);
        launch(38'd100, -18'sd3);
        wait_valid("100/-3", 39);
        check_result("100/-3", -33, 1, 1'b0, 1'b0);
        release_out("100/-3");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
